serial_adder: RTL and testbench



---
 rtl/serial_adder_if.sv | 31 +++
 rtl/serial_adder.sv | 138 +++++++++++++
 tb/tb_serial_adder.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The requester (master) drives start and both operands; the adder (slave)
// returns busy, the done pulse and the WIDTH+1-bit sum.
interface serial_adder_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] bit1;
   logic [WIDTH-1:0] bit2;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   final_answer;

   modport master (
      output start,
      output bit1,
      output bit2,
      input  busy,
      input  done,
      input  final_answer
   );

   modport slave (
      input  start,
      input  bit1,
      input  bit2,
      output busy,
      output done,
      output final_answer
   );
endinterface : serial_adder_if

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder step per clock, LSB first, with the
// carry kept in a flip-flop. Operands are captured on an accepted start and the
// WIDTH+1-bit unsigned sum (carry-out in the top bit) is valid while done is high
// and stays stable until the next accepted start.
module serial_adder #(
   parameter int WIDTH = 4
) (
   input logic           clk,
   input logic           reset,
   serial_adder_if.slave bus
);

   // Counter must hold 0..WIDTH and also index every bit of the WIDTH+1-bit sum.
   localparam int              CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Carry generate of a full adder.
   function automatic logic majority(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   // Sum output of a full adder.
   function automatic logic fa_sum(input logic x, input logic y, input logic z);
      return x ^ y ^ z;
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   sum_q, sum_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             sum_bit_s;
   logic             carry_s;

   // Full-adder step on the current LSBs and the stored carry.
   always_comb begin
      sum_bit_s = fa_sum(a_q[0], b_q[0], carry_q);
      carry_s   = majority(a_q[0], b_q[0], carry_q);
   end

   // Next-state, datapath and output-flag decode; busy/done are computed for the
   // state being entered so that both leave the block straight from flops.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               // Capture operands and clear the result so stale upper bits
               // from the previous sum never mix with the new one.
               a_d     = bus.bit1;
               b_d     = bus.bit2;
               carry_d = 1'b0;
               cnt_d   = '0;
               sum_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end

         RUN: begin
            // Requests arriving here are dropped; operands are not touched.
            carry_d        = carry_s;
            sum_d[cnt_q]   = sum_bit_s;
            a_d            = a_q >> 1;
            b_d            = b_q >> 1;
            cnt_d          = cnt_q + CNT_ONE;
            if (cnt_q == LAST_BIT) begin
               sum_d[WIDTH] = carry_s;
               done_d       = 1'b1;
               state_d      = DONE;
            end else begin
               busy_d       = 1'b1;
               state_d      = RUN;
            end
         end

         DONE: begin
            // One-cycle result strobe, then back to IDLE whatever start says.
            state_d = IDLE;
         end

         default: begin
            // Unreachable encoding: fall back to a safe idle state.
            state_d = IDLE;
            carry_d = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // State and datapath registers; synchronous reset aborts any operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.final_answer = sum_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: WIDTH=4 scenarios plus an
// exhaustive 4-bit sweep, and a WIDTH=8 instance driven with random pairs.
module tb_serial_adder;

   logic clk;
   logic reset;
   int   vec_cnt;
   int   err_cnt;

   serial_adder_if #(.WIDTH(4)) bus4 ();
   serial_adder_if #(.WIDTH(8)) bus8 ();

   serial_adder #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4)
   );

   serial_adder #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one WIDTH=4 operation from IDLE and collect what it did.
   task automatic do_op4(input logic [3:0] a, input logic [3:0] b,
                         output logic [4:0] res, output logic [4:0] first_fa,
                         output logic [4:0] hold_fa, output int lat,
                         output int busy_cnt, output int done_cnt);
      bus4.bit1  = a;
      bus4.bit2  = b;
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      bus4.bit1  = ~a;
      bus4.bit2  = ~b;
      first_fa   = bus4.final_answer;
      lat        = 0;
      busy_cnt   = 0;
      done_cnt   = 0;
      while (bus4.done !== 1'b1 && lat < 40) begin
         if (bus4.busy === 1'b1) busy_cnt++;
         tick();
         lat++;
      end
      res = bus4.final_answer;
      for (int i = 0; i < 4; i++) begin
         if (bus4.done === 1'b1) done_cnt++;
         tick();
      end
      hold_fa = bus4.final_answer;
   endtask

   // Launch one WIDTH=8 operation from IDLE and return the sum seen with done.
   task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                         output logic [8:0] res, output int lat);
      bus8.bit1  = a;
      bus8.bit2  = b;
      bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      bus8.bit1  = 8'h00;
      bus8.bit2  = 8'h00;
      lat        = 0;
      while (bus8.done !== 1'b1 && lat < 60) begin
         tick();
         lat++;
      end
      res = bus8.final_answer;
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      bus4.start = 1'b0;
      bus4.bit1  = 4'd0;
      bus4.bit2  = 4'd0;
      bus8.start = 1'b0;
      bus8.bit1  = 8'd0;
      bus8.bit2  = 8'd0;
      tick();
      tick();
      reset = 1'b0;
      vec_cnt++;
      if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.final_answer !== 5'd0) begin
         err_cnt++;
         $display("FAIL reset_state: busy=%b done=%b fa=%b, required 0 0 00000",
                  bus4.busy, bus4.done, bus4.final_answer);
      end
      vec_cnt++;
      if (bus8.busy !== 1'b0 || bus8.final_answer !== 9'd0) begin
         err_cnt++;
         $display("FAIL reset_state8: busy=%b fa=%h, required 0 000", bus8.busy, bus8.final_answer);
      end
      // Reset and start together: start must be ignored.
      bus4.bit1  = 4'd3;
      bus4.bit2  = 4'd3;
      bus4.start = 1'b1;
      reset      = 1'b1;
      tick();
      reset      = 1'b0;
      bus4.start = 1'b0;
      tick();
      vec_cnt++;
      if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_wins: busy=%b done=%b, required 0 0", bus4.busy, bus4.done);
      end
   endtask

   task automatic test_basic();
      logic [4:0] res, first_fa, hold_fa;
      int lat, busy_cnt, done_cnt;
      do_op4(4'd5, 4'd3, res, first_fa, hold_fa, lat, busy_cnt, done_cnt);
      vec_cnt++;
      if (res !== 5'b01000) begin
         err_cnt++;
         $display("FAIL basic_sum: got %b, required 01000", res);
      end
      vec_cnt++;
      if (lat !== 4 || busy_cnt !== 4) begin
         err_cnt++;
         $display("FAIL basic_timing: latency=%0d busy_cycles=%0d, required 4 4", lat, busy_cnt);
      end
      vec_cnt++;
      if (done_cnt !== 1) begin
         err_cnt++;
         $display("FAIL basic_done_pulses: got %0d, required 1", done_cnt);
      end
      vec_cnt++;
      if (hold_fa !== 5'b01000) begin
         err_cnt++;
         $display("FAIL basic_hold: got %b, required 01000", hold_fa);
      end
   endtask

   task automatic test_carry();
      logic [4:0] res, first_fa, hold_fa;
      int lat, busy_cnt, done_cnt;
      do_op4(4'd15, 4'd15, res, first_fa, hold_fa, lat, busy_cnt, done_cnt);
      vec_cnt++;
      if (res !== 5'b11110 || res[4] !== 1'b1) begin
         err_cnt++;
         $display("FAIL carry_15_15: got %b, required 11110", res);
      end
      do_op4(4'd8, 4'd8, res, first_fa, hold_fa, lat, busy_cnt, done_cnt);
      vec_cnt++;
      if (first_fa !== 5'd0) begin
         err_cnt++;
         $display("FAIL clear_on_start: got %b, required 00000", first_fa);
      end
      vec_cnt++;
      if (res !== 5'b10000) begin
         err_cnt++;
         $display("FAIL carry_8_8: got %b, required 10000", res);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int done_cnt;
      // 0+0 with start held high; operands swapped to 9+6 right after acceptance.
      bus4.bit1  = 4'd0;
      bus4.bit2  = 4'd0;
      bus4.start = 1'b1;
      tick();
      bus4.bit1  = 4'd9;
      bus4.bit2  = 4'd6;
      lat = 0;
      while (bus4.done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      vec_cnt++;
      if (bus4.final_answer !== 5'd0 || lat !== 4) begin
         err_cnt++;
         $display("FAIL b2b_zero: fa=%b latency=%0d, required 00000 4", bus4.final_answer, lat);
      end
      tick();
      vec_cnt++;
      if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
         err_cnt++;
         $display("FAIL b2b_idle_gap: busy=%b done=%b, required 0 0", bus4.busy, bus4.done);
      end
      tick();
      vec_cnt++;
      if (bus4.busy !== 1'b1) begin
         err_cnt++;
         $display("FAIL b2b_accept: busy=%b, required 1", bus4.busy);
      end
      bus4.start = 1'b0;
      lat = 0;
      while (bus4.done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      vec_cnt++;
      if (bus4.final_answer !== 5'b01111 || lat !== 4) begin
         err_cnt++;
         $display("FAIL b2b_9_6: fa=%b latency=%0d, required 01111 4", bus4.final_answer, lat);
      end
      done_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus4.done === 1'b1) done_cnt++;
         tick();
      end
      vec_cnt++;
      if (done_cnt !== 1) begin
         err_cnt++;
         $display("FAIL b2b_done_pulses: got %0d, required 1", done_cnt);
      end
   endtask

   task automatic test_ignored_start();
      int lat;
      int done_cnt;
      logic [4:0] res;
      bus4.bit1  = 4'd7;
      bus4.bit2  = 4'd2;
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      tick();
      bus4.bit1  = 4'd1;
      bus4.bit2  = 4'd1;
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      lat = 2;
      while (bus4.done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      res = bus4.final_answer;
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus4.done === 1'b1) done_cnt++;
         tick();
      end
      vec_cnt++;
      if (res !== 5'b01001 || lat !== 4) begin
         err_cnt++;
         $display("FAIL ignored_start_sum: fa=%b latency=%0d, required 01001 4", res, lat);
      end
      vec_cnt++;
      if (done_cnt !== 1) begin
         err_cnt++;
         $display("FAIL ignored_start_pulses: got %0d, required 1", done_cnt);
      end
   endtask

   task automatic test_reset_mid();
      logic [4:0] res, first_fa, hold_fa;
      int lat, busy_cnt, done_cnt;
      int stray;
      bus4.bit1  = 4'd12;
      bus4.bit2  = 4'd5;
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vec_cnt++;
      if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.final_answer !== 5'd0) begin
         err_cnt++;
         $display("FAIL reset_mid_state: busy=%b done=%b fa=%b, required 0 0 00000",
                  bus4.busy, bus4.done, bus4.final_answer);
      end
      stray = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus4.done === 1'b1 || bus4.busy === 1'b1) stray++;
         tick();
      end
      vec_cnt++;
      if (stray !== 0) begin
         err_cnt++;
         $display("FAIL reset_mid_quiet: got %0d active cycles, required 0", stray);
      end
      do_op4(4'd12, 4'd5, res, first_fa, hold_fa, lat, busy_cnt, done_cnt);
      vec_cnt++;
      if (res !== 5'b10001) begin
         err_cnt++;
         $display("FAIL reset_mid_rerun: got %b, required 10001", res);
      end
   endtask

   task automatic test_exhaustive4();
      logic [4:0] res, first_fa, hold_fa, exp;
      int lat, busy_cnt, done_cnt;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            do_op4(4'(a), 4'(b), res, first_fa, hold_fa, lat, busy_cnt, done_cnt);
            exp = 5'(a + b);
            vec_cnt++;
            if (res !== exp || lat !== 4 || done_cnt !== 1) begin
               err_cnt++;
               $display("FAIL sweep4 %0d+%0d: got %b lat=%0d pulses=%0d, required %b 4 1",
                        a, b, res, lat, done_cnt, exp);
            end
         end
      end
   endtask

   task automatic test_random8();
      logic [7:0] a, b;
      logic [8:0] res, exp;
      int lat;
      for (int n = 0; n < 1000; n++) begin
         a = 8'($urandom_range(255, 0));
         b = 8'($urandom_range(255, 0));
         if (n == 0) begin
            a = 8'd255;
            b = 8'd255;
         end
         do_op8(a, b, res, lat);
         exp = {1'b0, a} + {1'b0, b};
         vec_cnt++;
         if (res !== exp || lat !== 8) begin
            err_cnt++;
            $display("FAIL rand8 %0d+%0d: got %0d lat=%0d, required %0d 8", a, b, res, lat, exp);
         end
      end
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      test_reset();
      test_basic();
      test_carry();
      test_back_to_back();
      test_ignored_start();
      test_reset_mid();
      test_exhaustive4();
      test_random8();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule : tb_serial_adder
